// File: rtl/div_pipe_param.sv
// Fully pipelined restoring divider for DIV/DIVU/REM/REMU with RISC-V divide-by-zero
// and overflow results; ITERS restoring steps per stage, STAGES = WIDTH/ITERS stages.
module div_pipe_param #(
    parameter int WIDTH = 32,
    parameter int ITERS = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             i_valid,
    input  logic             i_signed,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);
    localparam int STAGES = WIDTH / ITERS;
    localparam int LAST   = STAGES - 1;

    // Operands are reduced to magnitudes; signs are carried alongside and re-applied at the end.
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] cond_dvd;
    logic [WIDTH-1:0] cond_dvs;
    logic             cond_dz;

    assign dvd_neg  = i_signed & i_dividend[WIDTH-1];
    assign dvs_neg  = i_signed & i_divisor[WIDTH-1];
    assign cond_dvd = dvd_neg ? -i_dividend : i_dividend;
    assign cond_dvs = dvs_neg ? -i_divisor : i_divisor;
    assign cond_dz  = (i_divisor == '0);

    logic [WIDTH-1:0] rem_reg  [STAGES];
    logic [WIDTH-1:0] quo_reg  [STAGES];
    logic [WIDTH-1:0] dvd_reg  [STAGES];
    logic [WIDTH-1:0] dvs_reg  [STAGES];
    logic [TAG_W-1:0] tag_reg  [STAGES];
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] neg_q_reg;
    logic [STAGES-1:0] neg_r_reg;
    logic [STAGES-1:0] dz_reg;

    logic [WIDTH-1:0] rem_next [STAGES];
    logic [WIDTH-1:0] quo_next [STAGES];
    logic [WIDTH-1:0] dvd_next [STAGES];

    // One stage worth of restoring steps; the trial value keeps the carry bit (WIDTH+1 wide).
    function automatic void div_iters(
        input  logic [WIDTH-1:0] rem_in,
        input  logic [WIDTH-1:0] quo_in,
        input  logic [WIDTH-1:0] dvd_in,
        input  logic [WIDTH-1:0] dvs,
        output logic [WIDTH-1:0] rem_out,
        output logic [WIDTH-1:0] quo_out,
        output logic [WIDTH-1:0] dvd_out
    );
        logic [WIDTH:0] trial;
        rem_out = rem_in;
        quo_out = quo_in;
        dvd_out = dvd_in;
        for (int i = 0; i < ITERS; i++) begin
            trial = {rem_out, dvd_out[WIDTH-1]};
            if (trial >= {1'b0, dvs}) begin
                rem_out = WIDTH'(trial - {1'b0, dvs});
                quo_out = {quo_out[WIDTH-2:0], 1'b1};
            end else begin
                rem_out = trial[WIDTH-1:0];
                quo_out = {quo_out[WIDTH-2:0], 1'b0};
            end
            dvd_out = dvd_out << 1;
        end
    endfunction

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            rem_next[s] = '0;
            quo_next[s] = '0;
            dvd_next[s] = '0;
        end
        div_iters('0, '0, cond_dvd, cond_dvs, rem_next[0], quo_next[0], dvd_next[0]);
        for (int s = 1; s < STAGES; s++) begin
            div_iters(rem_reg[s-1], quo_reg[s-1], dvd_reg[s-1], dvs_reg[s-1],
                      rem_next[s], quo_next[s], dvd_next[s]);
        end
    end

    // Reset wins over stall; a stalled edge freezes every stage, valid bits included.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                rem_reg[s] <= '0;
                quo_reg[s] <= '0;
                dvd_reg[s] <= '0;
                dvs_reg[s] <= '0;
                tag_reg[s] <= '0;
            end
            valid_reg <= '0;
            neg_q_reg <= '0;
            neg_r_reg <= '0;
            dz_reg    <= '0;
        end else if (!stall) begin
            for (int s = 0; s < STAGES; s++) begin
                rem_reg[s] <= rem_next[s];
                quo_reg[s] <= quo_next[s];
                dvd_reg[s] <= dvd_next[s];
            end
            dvs_reg[0]   <= cond_dvs;
            tag_reg[0]   <= i_tag;
            valid_reg[0] <= i_valid;
            neg_q_reg[0] <= dvd_neg ^ dvs_neg;
            neg_r_reg[0] <= dvd_neg;
            dz_reg[0]    <= cond_dz;
            for (int s = 1; s < STAGES; s++) begin
                dvs_reg[s]   <= dvs_reg[s-1];
                tag_reg[s]   <= tag_reg[s-1];
                valid_reg[s] <= valid_reg[s-1];
                neg_q_reg[s] <= neg_q_reg[s-1];
                neg_r_reg[s] <= neg_r_reg[s-1];
                dz_reg[s]    <= dz_reg[s-1];
            end
        end
    end

    // Divide-by-zero keeps the all-ones quotient unsigned so DIV x/0 still returns -1.
    assign o_valid       = valid_reg[LAST];
    assign o_tag         = tag_reg[LAST];
    assign o_div_by_zero = dz_reg[LAST];
    assign o_quotient    = (neg_q_reg[LAST] && !dz_reg[LAST]) ? -quo_reg[LAST] : quo_reg[LAST];
    assign o_remainder   = neg_r_reg[LAST] ? -rem_reg[LAST] : rem_reg[LAST];

endmodule

// File: doc/div_pipe_param.md
# div_pipe_param

Parametrised, fully pipelined integer divider for the RV32IM datapath's M-extension unit. It executes DIV, DIVU, REM and REMU with RISC-V divide-by-zero and overflow semantics. It accepts one operation per cycle and carries valid and tag sideband through the pipe. It sits beside the multiplier in execute and is gated by the global pipeline stall.

## Interface

Parameters:
- WIDTH, 32, operand width in bits; must be at least 2.
- ITERS, 4, restoring iterations per pipeline stage; must divide WIDTH exactly.
- TAG_W, 5, width of the sideband tag (destination register index).
- Derived: STAGES = WIDTH/ITERS, which is 8 at the defaults.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  when high, every pipeline register holds its value.
- i_valid  in  1  input operation present this cycle.
- i_signed  in  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU.
- i_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- i_dividend  in  WIDTH  dividend.
- i_divisor  in  WIDTH  divisor.
- o_valid  out  1  result at the output is valid.
- o_tag  out  TAG_W  tag of the output result.
- o_quotient  out  WIDTH  quotient, signed or unsigned per the op.
- o_remainder  out  WIDTH  remainder, signed or unsigned per the op.
- o_div_by_zero  out  1  the output op had divisor == 0 (informational only).

## Operation

- **Input conditioning (combinational, ahead of stage 0).**
  - Signed ops: convert each operand to its magnitude.
  - Record neg_q = sign(dividend) XOR sign(divisor).
  - Record neg_r = sign(dividend).
  - Record dz = (divisor == 0).
  - Unsigned ops: neg_q = neg_r = 0.
- **Core.** Unsigned restoring division over STAGES registered stages, ITERS iterations per stage.
  - Each iteration: r' = {r, msb(dividend)}, computed at WIDTH+1 bits.
  - If r' >= divisor: r = r' - divisor and shift in quotient bit 1.
  - Otherwise: r = r' and shift in quotient bit 0.
  - The dividend shifts left by 1 each iteration.
  - Initial remainder and quotient are 0.
  - The comparison is WIDTH+1 bits; truncating it to WIDTH bits is a bug.
- **Per-stage registers.** Each stage registers remainder, quotient, shifted dividend, divisor magnitude, valid, tag, neg_q, neg_r and dz.
- **Output fix-up (combinational, from the last stage).**
  - o_quotient = neg_q && !dz ? -q : q.
  - o_remainder = neg_r ? -r : r.
- **Divide by zero** (falls out of the algorithm plus the dz gating above):
  - o_quotient = all ones.
  - o_remainder = original i_dividend, for both signed and unsigned ops.
  - o_div_by_zero = 1.
- **Signed overflow** (-2^(WIDTH-1) / -1):
  - o_quotient = 0x80000000.
  - o_remainder = 0.
  - No special-case logic; the magnitude path yields this result naturally.
- **Sideband.** i_valid = 0 still advances the pipe. A bubble's datapath contents are don't-care, but its valid bit must be 0.
- **Ordering.** Results emerge strictly in issue order; there is no reordering and no early-out.

## Timing

- **Latency.** Exactly STAGES cycles (8 at defaults). An op presented with i_valid = 1 at rising edge k (stall low) appears on the outputs after edge k+STAGES-1, provided stall stays low.
- **Throughput.** One op per cycle.
- **Stall.**
  - Stall high at an edge freezes every stage, including valid and tag. The input is not captured.
  - The outputs hold their values, and o_valid holds too, so the consumer must qualify results with its own stall.
  - Bubbles are never collapsed during a stall.
- **Reset.**
  - Reset at an edge clears every stage register to 0, including all valid bits.
  - After reset: o_valid = 0, o_tag = 0, o_quotient = 0, o_remainder = 0, o_div_by_zero = 0.
  - Reset has priority over stall.
  - Reset mid-operation discards all in-flight ops; none reappear afterwards.
- **Input dependence.** Inputs are sampled only at stage-0 capture. Later changes to the inputs do not affect in-flight ops.

## Test plan

- **Unsigned basics.** DIVU 100/7, tag 3 -> 8 cycles later: q = 14, r = 2, tag 3, o_valid = 1. Also DIVU 0xFFFFFFFF/1 -> q = 0xFFFFFFFF, r = 0.
- **Signed sign cases.**
  - DIV -7/2 -> q = -3 (0xFFFFFFFD), r = -1 (0xFFFFFFFF).
  - DIV 7/-2 -> q = -3, r = 1.
  - DIV -7/-2 -> q = 3, r = -1.
- **Corner cases.**
  - DIV 0x80000000/0xFFFFFFFF -> q = 0x80000000, r = 0.
  - DIV -5/0 -> q = 0xFFFFFFFF, r = 0xFFFFFFFB, div_by_zero = 1.
  - DIVU 9/0 -> q = 0xFFFFFFFF, r = 9.
- **Back-to-back stream.** 20 consecutive random ops with unique tags, compared against a reference model. Required: results on 20 consecutive cycles, in order, tags matching.
- **Stall and bubbles.**
  - Issue op A, one bubble, then op B.
  - Assert stall for 3 cycles mid-flight. A and B each arrive exactly 3 cycles later than without the stall, the bubble shows o_valid = 0 between them, and outputs are frozen during the stall.
- **Reset mid-flight and parameters.**
  - With 4 ops in flight, pulse rst for one cycle. All outputs read 0, and no o_valid appears in the following 10 cycles.
  - Rerun the random stream with WIDTH=16, ITERS=2: latency is 8 cycles and results match the model.
